// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Receives 8N1 serial bytes from an asynchronous pin. Each byte goes out on a
// valid/ready interface. Framing errors and overruns are flagged with
// one-cycle pulses.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | line idle, waiting for a falling edge on the synchronized rxd
//  START | timing half a bit to confirm the start bit (rejects glitches)
//  DATA  | sampling 8 data bits, LSB first, one per bit period
//  STOP  | sampling the stop bit; a good stop delivers the byte
//  BREAK | stop bit was 0; waiting for the line to return high
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 347,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_rs232_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxd_s;

    state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_bit_idx, w_bit_idx_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       w_load;
    logic       w_frame_bad;

    // Pin synchronizer; resets to the idle-high line level so reset never fakes a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], usb_rs232_rxd};
        end
    end

    assign w_rxd_s = r_sync[SYNC_STAGES-1];

    // State, bit-timing counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Next-state logic. The counter free-runs and is cleared at each sample point.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_load        = 1'b0;
        w_frame_bad   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxd_s) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == MID) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = w_rxd_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {w_rxd_s, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rxd_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rxd_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output holding register and handshake. A new byte always wins over a pending one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_err <= w_frame_bad;
            if (w_load) begin
                rx_data     <= r_shift;
                rx_valid    <= 1'b1;
                overrun_err <= rx_valid & ~rx_ready;
            end else begin
                overrun_err <= 1'b0;
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

    assign rx_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: directed scenarios plus random frames, checked
// by a scoreboard queue that a negedge monitor drains.
module tb_uart_rx_deframer;

    localparam int CPB   = 24;
    localparam int SYNC  = 2;
    localparam int MID   = CPB / 2;
    localparam int LAT   = SYNC + 2 + MID + 9 * CPB;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    uart_rx_deframer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .usb_rs232_rxd(rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int  exp_ferr = 0;
    int  exp_ovr  = 0;
    int  obs_ferr = 0;
    int  obs_ovr  = 0;
    bit  m_held   = 0;
    int  t_fall   = 0;
    int  last_rise = 0;
    bit  prev_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Scoreboard monitor: a byte is consumed at the edge after valid & ready is seen.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err)   obs_ferr++;
            if (overrun_err) obs_ovr++;
            if (rx_valid && !prev_valid) last_rise = cyc;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", int'(rx_data), -1);
                end else begin
                    chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
                end
            end
        end
        prev_valid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; the reference model records what the receiver must report.
    task automatic send(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        t_fall = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        if (stop_ok) begin
            if (m_held && !rx_ready) begin
                void'(exp_q.pop_back());
                exp_ovr++;
            end
            exp_q.push_back(b);
            m_held = !rx_ready;
        end else begin
            exp_ferr++;
        end
        rxd = stop_ok;
        tick(CPB);
        rxd = 1'b1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * FRAME) begin
            tick(1);
            n++;
        end
        tick(CPB);
        chk({nm, "_pending"}, exp_q.size(), 0);
        chk({nm, "_frame_err"}, obs_ferr, exp_ferr);
        chk({nm, "_overrun"}, obs_ovr, exp_ovr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        rxd = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_overrun", int'(overrun_err), 0);
        chk("reset_busy", int'(rx_busy), 0);
        rst = 1'b1;
        tick(5);

        // Single byte and latency from the pin falling edge.
        send(8'h55, 1'b1);
        tick(4);
        drain("t1");
        chk("t1_latency", last_rise - t_fall, LAT);

        // Start-bit glitch shorter than half a bit.
        rxd = 1'b0;
        tick(SYNC + 2);
        chk("t2_busy_in_start", int'(rx_busy), 1);
        tick(MID - 4 - SYNC - 2);
        rxd = 1'b1;
        tick(MID + 10);
        chk("t2_busy_idle", int'(rx_busy), 0);
        chk("t2_no_valid", int'(rx_valid), 0);
        drain("t2");

        // Bad stop bit, then a clean frame.
        send(8'hA3, 1'b0);
        tick(4);
        chk("t3_no_valid", int'(rx_valid), 0);
        send(8'h3C, 1'b1);
        drain("t3");

        // Overrun with the consumer stalled.
        rx_ready = 1'b0;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        tick(4);
        chk("t4_valid_held", int'(rx_valid), 1);
        chk("t4_data_held", int'(rx_data), 8'h22);
        rx_ready = 1'b1;
        m_held = 0;
        drain("t4");

        // Back-to-back frames.
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h80, 1'b1);
        drain("t5");

        // Reset during data bit 4.
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            tick(CPB);
        end
        rxd = 1'b1;
        tick(MID);
        chk("t6_busy_before", int'(rx_busy), 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_data", int'(rx_data), 0);
        chk("t6_rst_valid", int'(rx_valid), 0);
        chk("t6_rst_busy", int'(rx_busy), 0);
        tick(3);
        rst = 1'b1;
        m_held = 0;
        tick(3);
        send(8'h5A, 1'b1);
        drain("t6");

        // Random frames with random gaps and occasional bad stop bits.
        for (int k = 0; k < 14; k++) begin
            logic [7:0] b;
            bit ok;
            int gap;
            b = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 20) + (ok ? 0 : 4);
            send(b, ok);
            tick(gap);
        end
        drain("rand");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
